// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with manual, fixed-priority and round-robin arbitration
// feeding a single registered output slot (y, y_ch, y_valid).
module stream_mux_rr #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [SW-1:0]    s,
    input  logic [N*W-1:0]   a,
    input  logic [N-1:0]     a_valid,
    output logic [N-1:0]     a_ready,
    output logic [W-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [SW-1:0]    y_ch
);

    logic [W-1:0]  r_y;
    logic [SW-1:0] r_y_ch;
    logic          r_y_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load_en;
    logic          w_grant_any;
    logic [SW-1:0] w_grant_idx;
    logic [N-1:0]  w_grant;
    logic          w_xfer;
    logic [W-1:0]  w_data;
    logic [SW-1:0] w_ptr_next;

    // Arbitration: pick at most one channel. Scans run from the lowest-priority
    // candidate upward so the last hit is the winner.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        case (mode)
            2'b00: begin
                if ((int'(s) < N) && a_valid[s]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = s;
                end else begin
                    w_grant_any = 1'b0;
                end
            end
            2'b01: begin
                for (int i = N - 1; i >= 0; i--) begin
                    w_grant_idx = a_valid[i] ? SW'(i) : w_grant_idx;
                    w_grant_any = w_grant_any | a_valid[i];
                end
            end
            default: begin
                for (int k = N - 1; k >= 0; k--) begin
                    w_grant_idx = a_valid[(int'(r_ptr) + k) % N] ? SW'((int'(r_ptr) + k) % N) : w_grant_idx;
                    w_grant_any = w_grant_any | a_valid[(int'(r_ptr) + k) % N];
                end
            end
        endcase
    end

    assign w_load_en  = rst_n & (~r_y_valid | y_ready);
    assign w_grant    = w_grant_any ? (N'(1) << w_grant_idx) : '0;
    assign a_ready    = w_grant & {N{w_load_en}};
    assign w_xfer     = w_grant_any & w_load_en;
    assign w_data     = a[int'(w_grant_idx)*W +: W];
    assign w_ptr_next = (int'(w_grant_idx) == N - 1) ? '0 : w_grant_idx + SW'(1);

    // Output slot and round-robin pointer; pointer only moves on a rotating-mode transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_ptr     <= '0;
        end else begin
            if (w_load_en) begin
                if (w_xfer) begin
                    r_y       <= w_data;
                    r_y_ch    <= w_grant_idx;
                    r_y_valid <= 1'b1;
                end else begin
                    r_y_valid <= 1'b0;
                end
            end
            if (w_xfer && mode[1]) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (N=4, W=8): expected words are queued when a
// transfer is predicted and compared while they sit in / leave the output slot.
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic [1:0]   s;
    logic [N*W-1:0] a;
    logic [N-1:0] a_valid;
    logic [N-1:0] a_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic [1:0]   y_ch;

    int n_total = 0;
    int n_bad   = 0;

    logic [9:0] sb[$];
    logic [9:0] m_last;
    bit         m_yv;
    int         m_ptr;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s(s), .a(a), .a_valid(a_valid),
        .a_ready(a_ready), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_ch(y_ch)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arbiter: round-robin picks the valid channel closest after the pointer.
    function automatic void model_grant(input logic [1:0] md, input logic [1:0] sel,
                                        input logic [3:0] v, input int ptr,
                                        output int idx, output bit any);
        int best;
        any = 1'b0;
        idx = 0;
        if (md == 2'b00) begin
            any = v[sel];
            idx = int'(sel);
        end else if (md == 2'b01) begin
            for (int i = N - 1; i >= 0; i--) if (v[i]) begin any = 1'b1; idx = i; end
        end else begin
            best = N;
            for (int i = 0; i < N; i++) begin
                if (v[i] && ((i - ptr + N) % N) < best) begin
                    best = (i - ptr + N) % N;
                    idx  = i;
                    any  = 1'b1;
                end
            end
        end
    endfunction

    task automatic step(input logic [1:0] md, input logic [1:0] sel, input logic [3:0] v,
                        input logic rdy, input logic [31:0] data);
        int  idx;
        bit  any;
        bit  le;
        logic [9:0] ent;
        mode = md; s = sel; a_valid = v; y_ready = rdy; a = data;
        #1;
        model_grant(md, sel, v, m_ptr, idx, any);
        le = !m_yv || rdy;
        check_eq("a_ready", a_ready, (le && any) ? (4'b0001 << idx) : 4'b0000);
        if (y_valid) begin
            check_eq("sb_size", sb.size(), 1);
            if (sb.size() > 0) begin
                check_eq("y", y, sb[0][7:0]);
                check_eq("y_ch", y_ch, sb[0][9:8]);
                if (rdy) ent = sb.pop_front();
            end
        end else begin
            check_eq("y_hold", y, m_last[7:0]);
            check_eq("y_ch_hold", y_ch, m_last[9:8]);
        end
        if (le) begin
            if (any) begin
                ent = {2'(idx), data[idx*W +: W]};
                sb.push_back(ent);
                m_last = ent;
                m_yv = 1'b1;
                if (md[1]) m_ptr = (idx + 1) % N;
            end else begin
                m_yv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("y_valid", y_valid, m_yv);
    endtask

    task automatic model_reset();
        sb.delete();
        m_last = '0;
        m_yv   = 1'b0;
        m_ptr  = 0;
    endtask

    task automatic release_reset();
        a_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("y_valid_after_rel", y_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b10; s = 2'd0; a = 32'h44332211; a_valid = 4'b1111; y_ready = 1'b1;
        model_reset();
        #1;
        check_eq("rst_y", y, 8'h00);
        check_eq("rst_y_ch", y_ch, 2'd0);
        check_eq("rst_y_valid", y_valid, 1'b0);
        check_eq("rst_a_ready", a_ready, 4'b0000);
        release_reset();

        for (int i = 0; i < 6; i++) step(2'b10, 2'd0, 4'b1111, 1'b1, 32'h44332211);
        for (int i = 0; i < 4; i++) step(2'b01, 2'd0, 4'b1010, 1'b1, 32'hA1B2C3D4);
        step(2'b00, 2'd2, 4'b0100, 1'b1, 32'h005A0000);
        step(2'b00, 2'd1, 4'b0100, 1'b1, 32'h005A0000);
        step(2'b00, 2'd1, 4'b0100, 1'b1, 32'h005A0000);

        step(2'b10, 2'd0, 4'b1111, 1'b1, 32'h44332211);
        for (int i = 0; i < 3; i++) step(2'b10, 2'd0, 4'b1111, 1'b0, 32'h44332211);
        for (int i = 0; i < 3; i++) step(2'b10, 2'd0, 4'b1111, 1'b1, 32'h44332211);

        step(2'b10, 2'd0, 4'b0100, 1'b1, 32'h80706050);
        step(2'b10, 2'd0, 4'b1000, 1'b1, 32'h80706050);
        step(2'b10, 2'd0, 4'b0001, 1'b1, 32'h80706050);
        step(2'b10, 2'd0, 4'b1111, 1'b1, 32'h80706050);

        step(2'b10, 2'd0, 4'b0010, 1'b0, 32'h12345678);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_y_valid", y_valid, 1'b0);
        check_eq("mid_rst_y", y, 8'h00);
        check_eq("mid_rst_y_ch", y_ch, 2'd0);
        check_eq("mid_rst_a_ready", a_ready, 4'b0000);
        model_reset();
        release_reset();
        step(2'b10, 2'd0, 4'b1111, 1'b1, 32'h44332211);
        step(2'b10, 2'd0, 4'b1111, 1'b1, 32'h44332211);

        for (int i = 0; i < 300; i++)
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0), $urandom);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
